// File: rtl/adder_pkg.sv
// Shared types and default geometry for the pipelined add/subtract unit.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_STAGE_BITS = 4;

endpackage

// File: rtl/pipelined_adder_if.sv
// Valid/ready operand and result bundle for pipelined_adder.
interface pipelined_adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry_in;
  op_e              op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, op_a, op_b, carry_in, op, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, op_a, op_b, carry_in, op, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );

endinterface

// File: rtl/adder_slice.sv
// Combinational N-bit ripple adder built from per-bit full adders.
module adder_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c_s;

  // Full-adder chain: sum is the 3-input XOR, carry is the majority of a, b, carry.
  always_comb begin
    c_s    = '0;
    c_s[0] = cin;
    sum    = '0;
    for (int i = 0; i < N; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c_s[i];
      c_s[i+1] = (a[i] & b[i]) | (a[i] & c_s[i]) | (b[i] & c_s[i]);
    end
    cout = c_s[N];
  end

endmodule

// File: rtl/pipelined_adder_chk.sv
// Elaboration-time geometry check for pipelined_adder.
module pipelined_adder_chk
  import adder_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int STAGE_BITS = DEF_STAGE_BITS
) ();

  if (STAGE_BITS < 1 || (WIDTH % STAGE_BITS) != 0) begin : g_bad_geometry
    $error("pipelined_adder: WIDTH must be a positive multiple of STAGE_BITS");
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one STAGE_BITS slice per stage with the carry registered
// between stages; a single advance enable freezes the whole pipe under back-pressure.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int STAGE_BITS = DEF_STAGE_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  pipelined_adder_if.slave bus
);

  localparam int STAGES = WIDTH / STAGE_BITS;
  localparam int PIPE   = (STAGES > 1) ? STAGES - 1 : 1;

  logic             adv_s;
  logic [WIDTH-1:0] b_prep_s;
  logic             c0_s;
  logic             valid_r [STAGES];
  logic             carry_r [STAGES];
  logic [WIDTH-1:0] sum_r   [STAGES];
  logic [WIDTH-1:0] a_r     [PIPE];
  logic [WIDTH-1:0] b_r     [PIPE];
  logic             ovf_r;

  pipelined_adder_chk #(.WIDTH(WIDTH), .STAGE_BITS(STAGE_BITS)) u_chk ();

  assign adv_s        = !valid_r[STAGES-1] || bus.out_ready;
  assign bus.in_ready = adv_s && rst_n;

  // Subtraction is A + ~B + 1, so the external carry is dropped in SUB mode.
  always_comb begin
    if (bus.op == OP_SUB) begin
      b_prep_s = ~bus.op_b;
      c0_s     = 1'b1;
    end else begin
      b_prep_s = bus.op_b;
      c0_s     = bus.carry_in;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0]      a_in_s;
    logic [WIDTH-1:0]      b_in_s;
    logic [WIDTH-1:0]      sum_in_s;
    logic [WIDTH-1:0]      sum_nxt_s;
    logic                  c_in_s;
    logic                  v_in_s;
    logic [STAGE_BITS-1:0] slice_sum_s;
    logic                  slice_co_s;

    if (k == 0) begin : g_first
      assign a_in_s   = bus.op_a;
      assign b_in_s   = b_prep_s;
      assign c_in_s   = c0_s;
      assign v_in_s   = bus.in_valid && bus.in_ready;
      assign sum_in_s = '0;
    end else begin : g_next
      assign a_in_s   = a_r[k-1];
      assign b_in_s   = b_r[k-1];
      assign c_in_s   = carry_r[k-1];
      assign v_in_s   = valid_r[k-1];
      assign sum_in_s = sum_r[k-1];
    end

    adder_slice #(.N(STAGE_BITS)) u_slice (
      .a   (a_in_s[k*STAGE_BITS +: STAGE_BITS]),
      .b   (b_in_s[k*STAGE_BITS +: STAGE_BITS]),
      .cin (c_in_s),
      .sum (slice_sum_s),
      .cout(slice_co_s)
    );

    // Merge this stage's slice into the partial result carried from upstream.
    always_comb begin
      sum_nxt_s = sum_in_s;
      sum_nxt_s[k*STAGE_BITS +: STAGE_BITS] = slice_sum_s;
    end

    // Stage result, carry and valid advance together.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_r[k] <= 1'b0;
        carry_r[k] <= 1'b0;
        sum_r[k]   <= '0;
      end else if (adv_s) begin
        valid_r[k] <= v_in_s;
        carry_r[k] <= slice_co_s;
        sum_r[k]   <= sum_nxt_s;
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_nxt_s;
      logic unused_ab_s;

      assign ovf_nxt_s   = (a_in_s[WIDTH-1] == b_in_s[WIDTH-1]) &&
                           (slice_sum_s[STAGE_BITS-1] != a_in_s[WIDTH-1]);
      assign unused_ab_s = ^{a_in_s, b_in_s};

      // Signed overflow is only knowable once the top slice is resolved.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_r <= 1'b0;
        end else if (adv_s) begin
          ovf_r <= ovf_nxt_s;
        end
      end
    end else begin : g_fwd
      // Operands ride along so later stages can consume their upper slices.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_r[k] <= '0;
          b_r[k] <= '0;
        end else if (adv_s) begin
          a_r[k] <= a_in_s;
          b_r[k] <= b_in_s;
        end
      end
    end
  end

  assign bus.out_valid = valid_r[STAGES-1];
  assign bus.sum       = sum_r[STAGES-1];
  assign bus.carry_out = carry_r[STAGES-1];
  assign bus.overflow  = ovf_r;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=16, STAGE_BITS=4): expected results are
// queued as beats are issued and popped by an independent monitor as results are consumed.
module tb_pipelined_adder;
  import adder_pkg::*;

  localparam int W   = 16;
  localparam int LAT = 4;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           acc;
    bit           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  int           cyc = 0;
  int           n_vec = 0;
  int           n_err = 0;
  exp_t         q[$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] held_sum = '0;
  logic         held_co = 1'b0;
  logic         held_ov = 1'b0;

  logic [W-1:0] va   [7] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h1234, 16'h8000, 16'h0007, 16'h00FF};
  logic [W-1:0] vb   [7] = '{16'h0001, 16'h0001, 16'h0007, 16'h4321, 16'h0001, 16'h0005, 16'h0F01};
  logic         vc   [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  op_e          vop  [7] = '{OP_ADD, OP_ADD, OP_SUB, OP_ADD, OP_SUB, OP_SUB, OP_ADD};
  logic [W-1:0] vs   [7] = '{16'h0000, 16'h8000, 16'hFFFE, 16'h5556, 16'h7FFF, 16'h0002, 16'h1000};
  logic         vco  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic         vov  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  logic [W-1:0] bb_a [8] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007};
  logic [W-1:0] bb_b [8] = '{16'h0000, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000, 16'h6000, 16'h7000};
  logic [W-1:0] bb_s [8] = '{16'h0000, 16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h5005, 16'h6006, 16'h7007};

  logic [W-1:0] bp_a [6] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
  logic [W-1:0] bp_s [6] = '{16'h1112, 16'h2223, 16'h3334, 16'h4445, 16'h5556, 16'h6667};

  pipelined_adder_if #(.WIDTH(W)) bus ();

  pipelined_adder #(.WIDTH(W), .STAGE_BITS(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input op_e o,
                      input logic [W-1:0] es, input logic eco, input logic eov, input bit lat);
    int   guard;
    exp_t e;
    guard = 0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.carry_in = cin;
    bus.op       = o;
    #1;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (guard >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready=%b, required 1", bus.in_ready);
      bus.in_valid = 1'b0;
    end else begin
      e.s   = es;
      e.co  = eco;
      e.ov  = eov;
      e.acc = cyc;
      e.lat = lat;
      q.push_back(e);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  // Monitor: checks every consumed result against the queue, and hold/ready during stalls.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_stall <= 1'b0;
    end else if (bus.out_valid === 1'b1) begin
      if (bus.out_ready !== 1'b1) begin
        chk("stall_in_ready", bus.in_ready, 0);
        if (prev_stall) begin
          chk("stall_sum_hold", bus.sum, held_sum);
          chk("stall_carry_hold", bus.carry_out, held_co);
          chk("stall_ovf_hold", bus.overflow, held_ov);
        end
        held_sum   <= bus.sum;
        held_co    <= bus.carry_out;
        held_ov    <= bus.overflow;
        prev_stall <= 1'b1;
      end else begin
        prev_stall <= 1'b0;
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got sum 0x%0h, required no result", bus.sum);
        end else begin
          chk("sum", bus.sum, q[0].s);
          chk("carry_out", bus.carry_out, q[0].co);
          chk("overflow", bus.overflow, q[0].ov);
          if (q[0].lat) chk("latency", cyc, q[0].acc + LAT);
          void'(q.pop_front());
        end
      end
    end else begin
      prev_stall <= 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.carry_in  = 1'b0;
    bus.op        = OP_ADD;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_carry", bus.carry_out, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      send(va[i], vb[i], vc[i], vop[i], vs[i], vco[i], vov[i], 1'b1);
      idle();
    end
    drain();

    for (int i = 0; i < 8; i++) begin
      send(bb_a[i], bb_b[i], 1'b0, OP_ADD, bb_s[i], 1'b0, 1'b0, 1'b1);
    end
    idle();
    drain();

    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(bp_a[i], 16'h0001, 1'b0, OP_ADD, bp_s[i], 1'b0, 1'b0, 1'b0);
        end
        idle();
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    send(16'h0101, 16'h0202, 1'b0, OP_ADD, 16'h0303, 1'b0, 1'b0, 1'b1);
    send(16'h0404, 16'h0505, 1'b0, OP_ADD, 16'h0909, 1'b0, 1'b0, 1'b1);
    send(16'h0606, 16'h0707, 1'b0, OP_ADD, 16'h0D0D, 1'b0, 1'b0, 1'b1);
    idle();
    @(posedge clk);
    #1;
    chk("pre_reset_out_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_sum", bus.sum, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_stale_result", bus.out_valid, 0);
    end
    send(16'hA5A5, 16'h5A5A, 1'b1, OP_ADD, 16'h0000, 1'b1, 1'b0, 1'b1);
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
